// File: rtl/uart_irq_ctrl_pkg.sv
// Shared definitions for the UART interrupt controller: IIR identification codes
// and IER enable bit positions.
package uart_irq_pkg;

  typedef enum logic [3:0] {
    IIR_NONE = 4'b0001,
    IIR_RLS  = 4'b0110,
    IIR_RDA  = 4'b0100,
    IIR_CTI  = 4'b1100,
    IIR_THRE = 4'b0010
  } iir_e;

  localparam int unsigned IER_RDA  = 0;
  localparam int unsigned IER_THRE = 1;
  localparam int unsigned IER_RLS  = 2;
  localparam int unsigned IER_CTI  = 3;

endpackage

// File: rtl/uart_irq_ctrl_if.sv
// Register-file / FIFO side signals of the UART interrupt controller.
// The slave modport is the controller; master is the register file and FIFOs.
interface uart_irq_ctrl_if #(
  parameter int unsigned RXW       = 6,
  parameter int unsigned TXW       = 6,
  parameter int unsigned TIMEOUT_W = 16
);
  logic [3:0]           ier_i;
  logic [RXW-1:0]       rx_elements_i;
  logic [TXW-1:0]       tx_elements_i;
  logic [RXW-1:0]       rx_thresh_i;
  logic [TXW-1:0]       tx_thresh_i;
  logic [TIMEOUT_W-1:0] timeout_cycles_i;
  logic                 rx_push_i;
  logic                 rx_pop_i;
  logic                 tx_push_i;
  logic                 line_err_i;
  logic                 lsr_rd_i;
  logic                 iir_rd_i;
  logic [3:0]           iir_o;
  logic                 interrupt_o;

  modport master (
    output ier_i, rx_elements_i, tx_elements_i, rx_thresh_i, tx_thresh_i,
           timeout_cycles_i, rx_push_i, rx_pop_i, tx_push_i, line_err_i,
           lsr_rd_i, iir_rd_i,
    input  iir_o, interrupt_o
  );

  modport slave (
    input  ier_i, rx_elements_i, tx_elements_i, rx_thresh_i, tx_thresh_i,
           timeout_cycles_i, rx_push_i, rx_pop_i, tx_push_i, line_err_i,
           lsr_rd_i, iir_rd_i,
    output iir_o, interrupt_o
  );
endinterface

// File: rtl/uart_irq_ctrl_char_timeout.sv
// Character-timeout timer: counts idle cycles while the RX FIFO holds data and
// pulses hit_o once per idle period when the count reaches timeout_cycles_i.
module uart_char_timeout #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 restart_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  output logic                 hit_o
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 fired_q;
  logic                 disabled;

  assign disabled = (timeout_cycles_i == '0);

  // The counter saturates at the limit, so fired_q keeps the hit to a single pulse.
  assign hit_o = ~restart_i & ~disabled & ~fired_q & (cnt_q == timeout_cycles_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i || disabled) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      if (cnt_q < timeout_cycles_i) begin
        cnt_q <= cnt_q + TIMEOUT_W'(1);
      end else begin
        cnt_q <= timeout_cycles_i;
      end
      if (hit_o) begin
        fired_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: sticky pending sources with 16550-style clears,
// FIFO threshold compares, character timeout and a priority-encoded IIR.
module uart_irq_ctrl
  import uart_irq_pkg::*;
#(
  parameter int unsigned RX_FIFO_DEPTH = 32,
  parameter int unsigned TX_FIFO_DEPTH = 32,
  parameter int unsigned TIMEOUT_W     = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  uart_irq_ctrl_if.slave bus
);

  localparam int unsigned RXW = $clog2(RX_FIFO_DEPTH) + 1;
  localparam int unsigned TXW = $clog2(TX_FIFO_DEPTH) + 1;

  logic [RXW-1:0] rx_level;
  logic [RXW-1:0] rx_thresh;
  logic [RXW-1:0] eff_rx_thresh;
  logic [TXW-1:0] tx_level;
  logic [TXW-1:0] tx_thresh;

  logic rx_restart;
  logic cti_hit;
  logic tx_low;
  logic tx_low_q;
  logic thre_rise;
  logic thre_clr;

  logic rls_p;
  logic rda_q;
  logic cti_p;
  logic thre_p;
  iir_e iir;

  assign rx_level  = bus.rx_elements_i;
  assign rx_thresh = bus.rx_thresh_i;
  assign tx_level  = bus.tx_elements_i;
  assign tx_thresh = bus.tx_thresh_i;

  always_comb begin
    eff_rx_thresh = rx_thresh;
    if ((rx_thresh == '0) || (rx_thresh > RXW'(RX_FIFO_DEPTH))) begin
      eff_rx_thresh = RXW'(1);
    end
  end

  assign rx_restart = bus.rx_push_i | bus.rx_pop_i | (rx_level == '0);
  assign tx_low     = (tx_level <= tx_thresh);
  assign thre_rise  = tx_low & ~tx_low_q;
  assign thre_clr   = bus.tx_push_i | (bus.iir_rd_i & (iir == IIR_THRE));

  uart_char_timeout #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_char_timeout (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .restart_i        (rx_restart),
    .timeout_cycles_i (bus.timeout_cycles_i),
    .hit_o            (cti_hit)
  );

  // Set terms take priority over clear terms for RLS and THRE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rls_p    <= 1'b0;
      rda_q    <= 1'b0;
      cti_p    <= 1'b0;
      thre_p   <= 1'b0;
      tx_low_q <= 1'b0;
    end else begin
      tx_low_q <= tx_low;
      rda_q    <= (rx_level >= eff_rx_thresh);

      if (bus.line_err_i) begin
        rls_p <= 1'b1;
      end else if (bus.lsr_rd_i) begin
        rls_p <= 1'b0;
      end

      if (rx_restart) begin
        cti_p <= 1'b0;
      end else if (cti_hit) begin
        cti_p <= 1'b1;
      end

      if (thre_rise) begin
        thre_p <= 1'b1;
      end else if (thre_clr) begin
        thre_p <= 1'b0;
      end
    end
  end

  always_comb begin
    iir = IIR_NONE;
    if (rls_p && bus.ier_i[IER_RLS]) begin
      iir = IIR_RLS;
    end else if (rda_q && bus.ier_i[IER_RDA]) begin
      iir = IIR_RDA;
    end else if (cti_p && bus.ier_i[IER_CTI]) begin
      iir = IIR_CTI;
    end else if (thre_p && bus.ier_i[IER_THRE]) begin
      iir = IIR_THRE;
    end
  end

  assign bus.iir_o       = iir;
  assign bus.interrupt_o = (iir != IIR_NONE);

endmodule
